// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - RV32I operand fetch stage with pending-write scoreboard and single output slot
//
// Ports:
//   clock, rst                  rising-edge clock, synchronous active-high reset
//   in_valid / in_ready         decoded-instruction handshake (in_ready does not look at in_valid)
//   in_rs1, in_rs2, in_rd       source / destination register indices
//   in_uses_rs1, in_uses_rs2    source operand use flags
//   in_writes_rd                instruction writes in_rd
//   in_pc                       instruction address, carried to out_pc
//   A1, A2 / RD1, RD2           register-file read addresses / combinational read data
//   wb_valid, wb_rd, wb_data    write-back port, same values the register file sees this edge
//   out_valid / out_ready       operand handshake to execute
//   out_op1, out_op2, out_rd,
//   out_writes_rd, out_pc       registered operand slot contents
//
// Build option: define OPERAND_BYPASS_EN to forward same-cycle write-back data
// into the operands instead of stalling until the register file holds it.

module operand_fetch (
    input  logic        clock,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_uses_rs1,
    input  logic        in_uses_rs2,
    input  logic        in_writes_rd,
    input  logic [31:0] in_pc,
    output logic [4:0]  A1,
    output logic [4:0]  A2,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [4:0]  out_rd,
    output logic        out_writes_rd,
    output logic [31:0] out_pc
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pending;

    logic        slot_free;
    logic        fwd1;
    logic        fwd2;
    logic        raw1;
    logic        raw2;
    logic        waw;
    logic        issue;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    assign A1 = in_rs1;
    assign A2 = in_rs2;

    assign out_valid = (state == FULL);

    // A FULL slot that is being drained this cycle can accept the next
    // instruction in the same cycle, giving one issue per clock.
    assign slot_free = (state == EMPTY) || out_ready;

`ifdef OPERAND_BYPASS_EN
    assign fwd1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
    assign fwd2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
`else
    // Without forwarding the source waits until the cycle after its pending
    // bit clears, when the register file read data is up to date.
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign raw1 = in_uses_rs1 && (in_rs1 != 5'd0) && pending[in_rs1] && !fwd1;
    assign raw2 = in_uses_rs2 && (in_rs2 != 5'd0) && pending[in_rs2] && !fwd2;

    // WAW stalls even when the pending write retires this cycle, so a set and
    // a clear of the same scoreboard bit can never land on one edge.
    assign waw = in_writes_rd && (in_rd != 5'd0) && pending[in_rd];

    assign in_ready = slot_free && !raw1 && !raw2 && !waw;
    assign issue    = in_valid && in_ready;

    always_comb begin
        op1 = RD1;
        if (in_rs1 == 5'd0) begin
            op1 = 32'd0;
        end else if (fwd1) begin
            op1 = wb_data;
        end
    end

    always_comb begin
        op2 = RD2;
        if (in_rs2 == 5'd0) begin
            op2 = 32'd0;
        end else if (fwd2) begin
            op2 = wb_data;
        end
    end

    // Clearing a bit that is not set is a no-op, so the clear mask does not
    // need to qualify on pending[wb_rd]. Bit 0 is masked off on both paths.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue && in_writes_rd && (in_rd != 5'd0)) begin
            set_mask = 32'd1 << in_rd;
        end
        if (wb_valid && (wb_rd != 5'd0)) begin
            clr_mask = 32'd1 << wb_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            pending <= 32'd0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

    // Output slot: data registers only load on issue, so they hold their last
    // value both while stalled and after draining back to EMPTY.
    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= EMPTY;
            out_op1       <= 32'd0;
            out_op2       <= 32'd0;
            out_rd        <= 5'd0;
            out_writes_rd <= 1'b0;
            out_pc        <= 32'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (issue) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready && !issue) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (issue) begin
                out_op1       <= op1;
                out_op2       <= op2;
                out_rd        <= in_rd;
                out_writes_rd <= in_writes_rd;
                out_pc        <= in_pc;
            end
        end
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: none; widths fixed at XLEN 32, 32 architectural registers (RV32I).
REQ-002 clock  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high; clock clock.
REQ-004 in_valid, in_ready  in/out  1  decoded-instruction handshake.
REQ-005 in_rs1, in_rs2, in_rd  in  5  source/destination register indices.
REQ-006 in_uses_rs1, in_uses_rs2, in_writes_rd  in  1  operand-use and write-back flags.
REQ-007 in_pc  in  32  instruction address, carried through.
REQ-008 A1, A2  out  5  register-file read addresses; RD1, RD2  in  32  combinational read data.
REQ-009 wb_valid  in  1, wb_rd  in  5, wb_data  in  32  write-back port, same values the register file receives on that edge.
REQ-010 out_valid, out_ready  out/in  1  operand handshake to execute stage.
REQ-011 out_op1, out_op2  out  32; out_rd  out  5; out_writes_rd  out  1; out_pc  out  32.

Function
REQ-012 A1 = in_rs1, A2 = in_rs2 combinationally, every cycle.
REQ-013 The block SHALL hold a 32-bit pending scoreboard; bit 0 SHALL never be set.
REQ-014 Output stage SHALL be a single register slot with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 Slot-free = EMPTY, or FULL with out_ready=1 (pass-through in the same cycle).
REQ-016 RAW hazard on rsN = in_uses_rsN, rsN != 0, and pending[rsN], unless the forwarding condition of REQ-029 holds.
REQ-017 WAW hazard = in_writes_rd, in_rd != 0, and pending[in_rd], regardless of a same-cycle write-back.
REQ-018 in_ready SHALL be slot-free AND no RAW hazard AND no WAW hazard; combinational, with no dependency on in_valid.
REQ-019 Issue = in_valid and in_ready; on issue, the slot SHALL capture operands, in_rd, in_writes_rd, and in_pc at the next edge, and the state SHALL become FULL.
REQ-020 Operand value: 0 if the index is 0; otherwise the forwarded wb_data per REQ-029; otherwise RDn.
REQ-021 On issue with in_writes_rd and in_rd != 0, pending[in_rd] SHALL set at the next edge.
REQ-022 wb_valid with wb_rd != 0 and pending[wb_rd] SHALL clear that bit at the next edge; write-back to a non-pending register or to x0 SHALL leave the scoreboard unchanged.
REQ-023 A set and a clear on the same index cannot coincide (WAW stall); set and clear on different indices SHALL both take effect.
REQ-024 FULL with out_ready=0: all out_* SHALL hold stable, and in_ready SHALL be 0.
REQ-025 FULL with out_ready=1 and no issue: state SHALL return to EMPTY; out_* data SHALL hold its last value.
REQ-026 Latency: issue to out_valid is 1 cycle; throughput is 1 per cycle when hazard-free.

Reset
REQ-027 While rst=1 at an edge: scoreboard SHALL be all 0; state EMPTY; out_valid=0; out_op1, out_op2, out_pc=0; out_rd=0; out_writes_rd=0.
REQ-028 Reset mid-operation SHALL discard the slot contents and all pending bits with no output handshake; in_ready SHALL be 1 on the first cycle after reset.

Configuration
REQ-029 Macro OPERAND_BYPASS_EN defined: when wb_valid, wb_rd == rsN, and rsN != 0, the RAW hazard on rsN SHALL be suppressed and the operand SHALL take wb_data.
REQ-030 Macro OPERAND_BYPASS_EN undefined: no forwarding; the source SHALL stall until the cycle after its pending bit clears and SHALL then read RDn.

Verification
REQ-031 After reset, issue addi x5 (rs1=x0, RD1=0xDEAD) -> out_op1=0 one cycle later, pending[5]=1.
REQ-032 pending[5]=1; issue rs1=x5 with wb_valid, wb_rd=5, wb_data=0x1234 in the same cycle -> bypass: out_op1=0x1234 next cycle; no bypass: in_ready=0 that cycle, issue next cycle with RD1 value.
REQ-033 pending[7]=1, in_writes_rd with in_rd=7 -> in_ready=0 until wb_rd=7 clears, then issue; pending[7]=1 again.
REQ-034 out_ready=0 for 3 cycles while FULL with out_op1=0xA5A5A5A5 -> outputs stable, in_ready=0; out_ready=1 -> back-to-back issue accepted the same cycle.
REQ-035 pending[3]=1, pending[9]=1; rst=1 for one cycle -> out_valid=0, scoreboard=0, rs1=x3 issue accepted immediately.
REQ-036 wb_valid with wb_rd=0 or a non-pending wb_rd=12 -> scoreboard unchanged.
